// File: rtl/uart_tx_arbiter.sv
// Round-robin, whole-message arbiter that feeds the UART TX ring buffer's strobed write port.
// Writes are paced to baud_x1, and a credit counter keeps the ring from overrunning.
module uart_tx_arbiter #(
    parameter int N_REQ = 2,
    parameter int DEPTH = 255,
    parameter int LVL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               baud_x1,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_last,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         buf_data,
    output logic               buf_strobe,
    input  logic               buf_pop,
    output logic [N_REQ-1:0]   grant,
    output logic               busy,
    output logic [LVL_W-1:0]   level
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, OPEN, STB_HI, STB_LO} state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] owner_reg;
    logic             msg_end_reg;
    logic [N_REQ-1:0] req_ready_reg;
    logic [N_REQ-1:0] grant_reg;
    logic [7:0]       buf_data_reg;
    logic             buf_strobe_reg;
    logic [LVL_W-1:0] level_reg;

    logic [7:0]       req_bytes [N_REQ];
    logic [IDX_W:0]   rr_sum    [N_REQ];
    logic [IDX_W-1:0] rr_idx    [N_REQ];

    // rr_idx[k] is the requester examined k-th, counting from the round-robin pointer.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign req_bytes[gi] = req_data[8*gi +: 8];
            assign rr_sum[gi]    = {1'b0, ptr_reg} + (IDX_W+1)'(gi);
            assign rr_idx[gi]    = (rr_sum[gi] >= (IDX_W+1)'(N_REQ))
                                 ? IDX_W'(rr_sum[gi] - (IDX_W+1)'(N_REQ))
                                 : rr_sum[gi][IDX_W-1:0];
        end
    endgenerate

    logic             win_found;
    logic [IDX_W-1:0] win_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && req_valid[rr_idx[k]]) begin
                win_found = 1'b1;
                win_idx   = rr_idx[k];
            end
        end
    end

    logic             accept;
    logic             pop_ok;
    logic [IDX_W-1:0] ptr_next;

    assign accept   = (state_reg == OPEN) && req_valid[owner_reg] && (level_reg < LVL_W'(DEPTH));
    assign pop_ok   = buf_pop && (level_reg != '0);
    assign ptr_next = (owner_reg == IDX_W'(N_REQ-1)) ? '0 : owner_reg + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            owner_reg      <= '0;
            msg_end_reg    <= 1'b0;
            req_ready_reg  <= '0;
            grant_reg      <= '0;
            buf_data_reg   <= 8'h00;
            buf_strobe_reg <= 1'b0;
            level_reg      <= '0;
        end else begin
            req_ready_reg <= '0;

            // A write and a pop in the same cycle cancel out.
            if (accept && !pop_ok)
                level_reg <= level_reg + LVL_W'(1);
            else if (!accept && pop_ok)
                level_reg <= level_reg - LVL_W'(1);

            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        grant_reg <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
                        owner_reg <= win_idx;
                        state_reg <= OPEN;
                    end
                end
                OPEN: begin
                    if (accept) begin
                        buf_data_reg             <= req_bytes[owner_reg];
                        req_ready_reg[owner_reg] <= 1'b1;
                        msg_end_reg              <= req_last[owner_reg];
                        buf_strobe_reg           <= 1'b1;
                        state_reg                <= STB_HI;
                    end
                end
                STB_HI: begin
                    if (baud_x1) begin
                        buf_strobe_reg <= 1'b0;
                        state_reg      <= STB_LO;
                    end
                end
                STB_LO: begin
                    // A full baud period low guarantees the buffer sees a fresh rising edge.
                    if (baud_x1) begin
                        if (msg_end_reg) begin
                            grant_reg <= '0;
                            ptr_reg   <= ptr_next;
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= OPEN;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign buf_data   = buf_data_reg;
    assign buf_strobe = buf_strobe_reg;
    assign grant      = grant_reg;
    assign busy       = (state_reg != IDLE);
    assign level      = level_reg;
endmodule
